// File: rtl/if_stage.sv
// if_stage: MIPS instruction fetch stage.
// Owns the PC, the imem handshake and the IF/ID register.
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000,
  parameter logic [31:0] EXC_VEC  = 32'h0000_4180,
  parameter logic [31:0] IMEM_LO  = 32'h0000_3000,
  parameter logic [31:0] IMEM_HI  = 32'h0000_6FFC
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] next_pc,
  input  logic        delay_slot_in,
  input  logic        stall,
  input  logic        exc_req,
  input  logic        eret,
  input  logic [31:0] epc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] pc_if,
  output logic [31:0] if_id_pc,
  output logic [31:0] if_id_instr,
  output logic        if_id_valid,
  output logic        if_id_ds,
  output logic [4:0]  if_id_exccode,
  output logic        fetch_busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    FULL = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic        kill_q, kill_d;
  logic [31:0] buf_q, buf_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] id_pc_q, id_pc_d;
  logic [31:0] id_instr_q, id_instr_d;
  logic        id_v_q, id_v_d;
  logic        id_ds_q, id_ds_d;
  logic [4:0]  id_exc_q, id_exc_d;

  logic        redirect;
  logic [31:0] target;
  logic        done;
  logic        advance;
  logic        pc_ok;
  logic        npc_ok;

  function automatic logic legal(input logic [31:0] a);
    return (a[1:0] == 2'b00) && (a >= IMEM_LO) && (a <= IMEM_HI);
  endfunction

  assign pc_ok    = legal(pc_q);
  assign npc_ok   = legal(next_pc);
  assign redirect = exc_req | eret;
  assign target   = exc_req ? EXC_VEC : epc;
  assign advance  = done & ~stall & ~redirect;

  assign fetch_busy    = ~done;
  assign pc_if         = pc_q;
  assign if_id_pc      = id_pc_q;
  assign if_id_instr   = id_instr_q;
  assign if_id_valid   = id_v_q;
  assign if_id_ds      = id_ds_q;
  assign if_id_exccode = id_exc_q;

  // an instruction is deliverable: bad PC, live rvalid, or parked word
  always_comb begin
    done = 1'b0;
    case (state_q)
      IDLE:    done = ~pc_ok;
      WAIT:    done = imem_rvalid & ~kill_q;
      FULL:    done = 1'b1;
      default: done = 1'b0;
    endcase
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= IDLE;
      kill_q  <= 1'b0;
      buf_q   <= '0;
    end else begin
      state_q <= state_d;
      kill_q  <= kill_d;
      buf_q   <= buf_d;
    end
  end

  // FSM next state, kill tracking and stall buffer capture
  always_comb begin
    state_d = state_q;
    kill_d  = kill_q;
    buf_d   = buf_q;
    case (state_q)
      IDLE: begin
        if (imem_req && imem_ack) state_d = WAIT;
      end
      WAIT: begin
        if (imem_rvalid) begin
          kill_d = 1'b0;
          if (redirect || kill_q) begin
            state_d = IDLE;
          end else if (stall) begin
            state_d = FULL;
            buf_d   = imem_rdata;
          end else if (imem_req && imem_ack) begin
            state_d = WAIT;
          end else begin
            state_d = IDLE;
          end
        end else if (redirect) begin
          kill_d = 1'b1;
        end
      end
      FULL: begin
        if (redirect || advance) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs: fetch request, back-to-back on a consumed rvalid
  always_comb begin
    imem_req  = 1'b0;
    imem_addr = pc_q;
    if (reset_n && !redirect) begin
      case (state_q)
        IDLE: imem_req = pc_ok;
        WAIT: begin
          if (advance) begin
            imem_req  = npc_ok;
            imem_addr = next_pc;
          end
        end
        default: imem_req = 1'b0;
      endcase
    end
  end

  // PC and IF/ID next values: redirect flushes, advance loads
  always_comb begin
    pc_d       = pc_q;
    id_pc_d    = id_pc_q;
    id_instr_d = id_instr_q;
    id_v_d     = id_v_q;
    id_ds_d    = id_ds_q;
    id_exc_d   = id_exc_q;
    if (redirect) begin
      pc_d       = target;
      id_instr_d = '0;
      id_v_d     = 1'b0;
      id_ds_d    = 1'b0;
      id_exc_d   = '0;
    end else if (advance) begin
      pc_d     = next_pc;
      id_pc_d  = pc_q;
      id_v_d   = 1'b1;
      id_ds_d  = delay_slot_in;
      id_exc_d = pc_ok ? 5'd0 : 5'd4;
      case (state_q)
        WAIT:    id_instr_d = imem_rdata;
        FULL:    id_instr_d = buf_q;
        default: id_instr_d = '0;
      endcase
    end
  end

  // PC and IF/ID registers
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      pc_q       <= RESET_PC;
      id_pc_q    <= '0;
      id_instr_q <= '0;
      id_v_q     <= 1'b0;
      id_ds_q    <= 1'b0;
      id_exc_q   <= '0;
    end else begin
      pc_q       <= pc_d;
      id_pc_q    <= id_pc_d;
      id_instr_q <= id_instr_d;
      id_v_q     <= id_v_d;
      id_ds_q    <= id_ds_d;
      id_exc_q   <= id_exc_d;
    end
  end

endmodule

// File: tb/tb_if_stage.sv
// tb_if_stage: directed + random fetch checks against
// an instruction-stream reference model and an imem model.
module tb_if_stage;

  localparam logic [31:0] RST = 32'h0000_3000;
  localparam logic [31:0] VEC = 32'h0000_4180;
  localparam logic [31:0] LO  = 32'h0000_3000;
  localparam logic [31:0] HI  = 32'h0000_6FFC;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [31:0] next_pc = '0;
  logic        delay_slot_in = 1'b0;
  logic        stall = 1'b0;
  logic        exc_req = 1'b0;
  logic        eret = 1'b0;
  logic [31:0] epc = '0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic [31:0] pc_if;
  logic [31:0] if_id_pc;
  logic [31:0] if_id_instr;
  logic        if_id_valid;
  logic        if_id_ds;
  logic [4:0]  if_id_exccode;
  logic        fetch_busy;
  logic        ack_en = 1'b0;

  assign imem_ack = imem_req & ack_en;

  always #5 clk = ~clk;

  if_stage dut (
    .clk(clk),
    .reset_n(reset_n),
    .next_pc(next_pc),
    .delay_slot_in(delay_slot_in),
    .stall(stall),
    .exc_req(exc_req),
    .eret(eret),
    .epc(epc),
    .imem_req(imem_req),
    .imem_addr(imem_addr),
    .imem_ack(imem_ack),
    .imem_rvalid(imem_rvalid),
    .imem_rdata(imem_rdata),
    .pc_if(pc_if),
    .if_id_pc(if_id_pc),
    .if_id_instr(if_id_instr),
    .if_id_valid(if_id_valid),
    .if_id_ds(if_id_ds),
    .if_id_exccode(if_id_exccode),
    .fetch_busy(fetch_busy)
  );

  int n_chk = 0;
  int n_pass = 0;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  function automatic bit legal(input logic [31:0] a);
    return (a[1:0] == 2'b00) && (a >= LO) && (a <= HI);
  endfunction

  function automatic logic [31:0] word(input logic [31:0] a);
    if (a == 32'h0000_3000) return 32'h2401_0001;
    return a ^ 32'h2400_A5A5;
  endfunction

  function automatic logic [31:0] rand_addr();
    int unsigned r;
    r = $urandom_range(0, 9);
    if (r == 0) return 32'h0000_3002;
    if (r == 1) return 32'h0000_1000;
    if (r == 2) return 32'h0000_7000;
    return LO + ($urandom_range(0, 32'hFFF) << 2);
  endfunction

  // knobs
  bit          rnd = 1'b0;
  int          lat = 0;
  bit          f_stall = 1'b0;
  bit          f_exc = 1'b0;
  bit          f_eret = 1'b0;
  bit          f_ds = 1'b0;
  logic [31:0] f_epc = '0;
  bit          np_use = 1'b0;
  logic [31:0] np_ovr = '0;
  bit          stale = 1'b0;

  // imem model: one outstanding word
  bit          m_busy = 1'b0;
  int          m_cnt = 0;
  logic [31:0] m_addr = '0;

  // architectural model
  logic [31:0] m_pc = RST;
  logic [31:0] e_pc = '0;
  logic [31:0] e_in = '0;
  logic        e_v = 1'b0;
  logic        e_ds = 1'b0;
  logic [4:0]  e_ex = '0;
  int          n_del = 0;

  // per-step observations
  bit          s_adv;
  bit          s_req;
  bit          s_busy;
  logic [31:0] s_addr;

  task automatic step();
    bit          redir;
    bit          acc;
    bit          rv;
    logic [31:0] tgt;
    @(negedge clk);
    if (rnd) begin
      stall         = ($urandom_range(0, 3) == 0);
      exc_req       = ($urandom_range(0, 19) == 0);
      eret          = ($urandom_range(0, 19) == 0);
      epc           = ($urandom_range(0, 7) == 0) ?
                      32'h0000_3002 : rand_addr();
      delay_slot_in = $urandom_range(0, 1);
      ack_en        = ($urandom_range(0, 3) != 0);
      next_pc       = ($urandom_range(0, 9) == 0) ?
                      rand_addr() : m_pc + 32'd4;
    end else begin
      stall         = f_stall;
      exc_req       = f_exc;
      eret          = f_eret;
      epc           = f_epc;
      delay_slot_in = f_ds;
      ack_en        = 1'b1;
      next_pc       = np_use ? np_ovr : m_pc + 32'd4;
    end
    imem_rvalid = m_busy && (m_cnt == 0);
    imem_rdata  = imem_rvalid ? word(m_addr) : 32'hDEAD_BEEF;
    if (stale) begin
      imem_rvalid = 1'b1;
      imem_rdata  = 32'hBAD0_0BAD;
      ack_en      = 1'b0;
    end
    #1;
    s_req  = imem_req;
    s_addr = imem_addr;
    s_busy = fetch_busy;
    acc    = imem_ack;
    rv     = imem_rvalid;
    redir  = exc_req | eret;
    tgt    = exc_req ? VEC : epc;
    s_adv  = reset_n && !s_busy && !stall && !redir;
    if (!reset_n) begin
      check("req_in_reset", s_req, 0);
    end else begin
      if (redir) check("req_on_redirect", s_req, 0);
      if (s_req) begin
        check("req_addr", s_addr, s_adv ? next_pc : m_pc);
        check("req_legal", legal(s_addr), 1);
      end
      if (m_busy && !rv) check("one_outstanding", s_req, 0);
    end
    @(posedge clk);
    if (!reset_n) begin
      m_busy = 1'b0;
    end else begin
      if (rv && !stale) m_busy = 1'b0;
      else if (m_busy) m_cnt--;
      if (acc) begin
        m_busy = 1'b1;
        m_addr = s_addr;
        m_cnt  = rnd ? $urandom_range(0, 3) : lat;
      end
    end
    if (!reset_n) begin
      m_pc = RST;
      e_pc = '0; e_in = '0; e_v = 0; e_ds = 0; e_ex = '0;
    end else if (redir) begin
      m_pc = tgt;
      e_in = '0; e_v = 0; e_ds = 0; e_ex = '0;
    end else if (s_adv) begin
      e_pc  = m_pc;
      e_in  = legal(m_pc) ? word(m_pc) : 32'h0;
      e_ex  = legal(m_pc) ? 5'd0 : 5'd4;
      e_ds  = delay_slot_in;
      e_v   = 1'b1;
      m_pc  = next_pc;
      n_del++;
    end
    #1;
    check("pc_if", pc_if, m_pc);
    check("if_id_pc", if_id_pc, e_pc);
    check("if_id_instr", if_id_instr, e_in);
    check("if_id_valid", if_id_valid, e_v);
    check("if_id_ds", if_id_ds, e_ds);
    check("if_id_exccode", if_id_exccode, e_ex);
  endtask

  task automatic run_until_adv(input int max, input string tag);
    for (int i = 0; i < max; i++) begin
      step();
      if (s_adv) return;
    end
    check(tag, 0, 1);
  endtask

  initial begin
    int cnt;
    bit seen;
    // reset and zero-wait streaming
    reset_n = 1'b0;
    step();
    step();
    check("rst_pc", pc_if, RST);
    check("rst_valid", if_id_valid, 0);
    reset_n = 1'b1;
    step();
    check("c0_req", s_req, 1);
    check("c0_addr", s_addr, 32'h0000_3000);
    step();
    check("c1_adv", s_adv, 1);
    check("c1_req", s_req, 1);
    check("c1_addr", s_addr, 32'h0000_3004);
    check("c1_instr", if_id_instr, 32'h2401_0001);
    check("c1_valid", if_id_valid, 1);
    cnt = 1;
    for (int i = 0; i < 8; i++) begin
      step();
      if (s_adv) cnt++;
    end
    check("throughput", cnt, 9);

    // stall across rvalid parks the word
    f_stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("stall_noreq", s_req, 0);
    end
    f_stall = 1'b0;
    step();
    check("unstall_busy", s_busy, 0);
    check("unstall_adv", s_adv, 1);

    // exception while a slow fetch is in flight
    lat = 2;
    step();
    check("exc_pre_req", s_req, 1);
    f_exc = 1'b1;
    step();
    f_exc = 1'b0;
    check("exc_valid", if_id_valid, 0);
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      step();
      if (s_req) begin
        seen = 1'b1;
        check("exc_req_addr", s_addr, VEC);
      end
    end
    check("exc_req_seen", seen, 1);
    run_until_adv(10, "exc_deliver_timeout");
    check("exc_id_pc", if_id_pc, VEC);
    check("exc_id_instr", if_id_instr, word(VEC));
    lat = 0;

    // illegal fetch addresses
    np_use = 1'b1;
    np_ovr = 32'h0000_3002;
    run_until_adv(10, "ill_a_timeout");
    np_ovr = 32'h0000_1000;
    run_until_adv(10, "ill_b_timeout");
    check("ill_b_pc", if_id_pc, 32'h0000_3002);
    check("ill_b_exc", if_id_exccode, 4);
    check("ill_b_instr", if_id_instr, 0);
    np_ovr = 32'h0000_3100;
    run_until_adv(10, "ill_c_timeout");
    check("ill_c_pc", if_id_pc, 32'h0000_1000);
    check("ill_c_exc", if_id_exccode, 4);
    check("ill_c_valid", if_id_valid, 1);

    // delay slot capture, then exc + eret together
    np_ovr = 32'h0000_3104;
    f_ds = 1'b1;
    run_until_adv(10, "ds_timeout");
    f_ds = 1'b0;
    check("ds_pc", if_id_pc, 32'h0000_3100);
    check("ds_flag", if_id_ds, 1);
    np_use = 1'b0;
    f_exc  = 1'b1;
    f_eret = 1'b1;
    f_epc  = 32'h0000_3010;
    step();
    f_exc  = 1'b0;
    f_eret = 1'b0;
    check("exc_wins", pc_if, VEC);

    // reset during an outstanding fetch
    lat = 3;
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      step();
      seen = s_req;
    end
    check("rw_req_seen", seen, 1);
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    check("rw_pc", pc_if, RST);
    lat = 0;
    stale = 1'b1;
    step();
    stale = 1'b0;
    check("rw_stale_valid", if_id_valid, 0);
    run_until_adv(10, "rw_timeout");
    check("rw_id_pc", if_id_pc, RST);
    check("rw_id_instr", if_id_instr, word(RST));

    // random traffic
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    rnd = 1'b1;
    cnt = n_del;
    for (int i = 0; i < 3000; i++) step();
    check("progress", (n_del - cnt) > 100, 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
